// File: rtl/pc_sequencer.sv
// Next-PC controller for the pipelined MIPS core.
// Picks the address the PC register loads on the next edge: reset vector,
// sequential fetch, jump/branch target, a redirect buffered during a stall,
// or the current PC (hold). It also raises the IF/ID flush, keeps a sticky
// halt state and saturating fetch/stall statistics counters.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   BOOT  | first cycle after reset, fetch RESET_VECTOR, flush IF
//   RUN   | normal operation, prioritised next-PC selection
//   HALT  | core halted, PC held, IF flushed, counters frozen
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             stall,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             halt_req,
    output logic [31:0]      next,
    output logic             if_id_flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [31:0]      next_raw;
    logic [31:0]      pc_plus4;
    logic             flush;
    logic             fetch_inc;
    logic             stall_inc;

    // Sequential fetch address, wraps modulo 2^32.
    assign pc_plus4 = pc + 32'd4;

    // State, pending redirect and statistics registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= BOOT;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= 32'h0000_0000;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Next-state, next-PC selection and flush, first match wins in RUN.
    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;
        next_raw     = pc;
        flush        = 1'b0;
        fetch_inc    = 1'b0;
        stall_inc    = 1'b0;

        case (state_q)
            BOOT: begin
                next_raw = RESET_VECTOR;
                flush    = 1'b1;
                state_d  = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    next_raw     = pc;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = HALT;
                end else if (stall) begin
                    next_raw  = pc;
                    stall_inc = 1'b1;
                    // Newest redirect wins; jump outranks a same-cycle branch.
                    if (jump) begin
                        pend_tgt_d   = jump_target;
                        pend_valid_d = 1'b1;
                    end else if (branch_taken) begin
                        pend_tgt_d   = branch_target;
                        pend_valid_d = 1'b1;
                    end
                end else if (pend_valid_q) begin
                    // Redirect inputs this cycle belong to the wrong path.
                    next_raw     = pend_tgt_q;
                    flush        = 1'b1;
                    pend_valid_d = 1'b0;
                    fetch_inc    = 1'b1;
                end else if (jump) begin
                    next_raw  = jump_target;
                    flush     = 1'b1;
                    fetch_inc = 1'b1;
                end else if (branch_taken) begin
                    next_raw  = branch_target;
                    flush     = 1'b1;
                    fetch_inc = 1'b1;
                end else begin
                    next_raw  = pc_plus4;
                    fetch_inc = 1'b1;
                end
            end
            HALT: begin
                next_raw = pc;
                flush    = 1'b1;
            end
            default: begin
                next_raw = RESET_VECTOR;
                flush    = 1'b1;
                state_d  = BOOT;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_inc && (fetch_cnt_q != CNT_MAX)) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Targets are word-aligned by truncating the low two bits.
    assign next        = next_raw & 32'hFFFF_FFFC;
    assign if_id_flush = flush;
    assign halted      = (state_q == HALT);
    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (CNT_W=4, RESET_VECTOR=0x0040_0000).
module tb_pc_sequencer;

    localparam logic [31:0] RV    = 32'h0040_0000;
    localparam int          CNT_W = 4;

    logic             clock;
    logic             reset;
    logic [31:0]      pc;
    logic             stall;
    logic             jump;
    logic [31:0]      jump_target;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             halt_req;
    logic [31:0]      next;
    logic             if_id_flush;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    logic [CNT_W-1:0] stall_count;

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        halt;
        logic [31:0] exp_next;
        logic        exp_flush;
    } step_t;

    typedef struct {
        logic [31:0] nxt;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    pc_sequencer #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .next          (next),
        .if_id_flush   (if_id_flush),
        .halted        (halted),
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic step_t mk(input logic [31:0] p, input logic s, input logic j,
                                 input logic [31:0] jt, input logic b, input logic [31:0] bt,
                                 input logic h, input logic [31:0] en, input logic ef);
        step_t r;
        r.pc = p; r.stall = s; r.jump = j; r.jt = jt; r.br = b; r.bt = bt;
        r.halt = h; r.exp_next = en; r.exp_flush = ef;
        return r;
    endfunction

    task automatic apply(input step_t s);
        exp_t e;
        pc            = s.pc;
        stall         = s.stall;
        jump          = s.jump;
        jump_target   = s.jt;
        branch_taken  = s.br;
        branch_target = s.bt;
        halt_req      = s.halt;
        e.nxt   = s.exp_next;
        e.flush = s.exp_flush;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        step_t st[3];
        exp_t  e;
        reset = 1'b1;
        apply(mk(32'h0, 0, 0, 0, 0, 0, 0, RV, 1));
        @(negedge clock);
        @(negedge clock);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (next !== e.nxt || if_id_flush !== e.flush || halted !== 1'b0 ||
            fetch_count !== 4'd0 || stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL reset_hold: next=%h flush=%b halted=%b fc=%0d sc=%0d, required next=%h flush=%b halted=0 fc=0 sc=0",
                     next, if_id_flush, halted, fetch_count, stall_count, e.nxt, e.flush);
        end
        @(negedge clock);
        reset = 1'b0;
        st[0] = mk(32'h0,         0, 0, 0, 0, 0, 0, RV,               1);
        st[1] = mk(RV,            0, 0, 0, 0, 0, 0, 32'h0040_0004,    0);
        st[2] = mk(32'h0040_0004, 0, 0, 0, 0, 0, 0, 32'h0040_0008,    0);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush) begin
                n_err++;
                $display("FAIL boot_seq step %0d: next=%h flush=%b, required next=%h flush=%b",
                         i, next, if_id_flush, e.nxt, e.flush);
            end
            tick();
        end
        n_cmp++;
        if (fetch_count !== 4'd2) begin
            n_err++;
            $display("FAIL boot_fetch_count: got %0d, required 2", fetch_count);
        end
    endtask

    task automatic test_jump_priority();
        step_t st[2];
        exp_t  e;
        st[0] = mk(32'h100, 0, 1, 32'h200, 1, 32'h300, 0, 32'h200, 1);
        st[1] = mk(32'h200, 0, 0, 32'h0,   0, 32'h0,   0, 32'h204, 0);
        for (int i = 0; i < 2; i++) begin
            apply(st[i]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush) begin
                n_err++;
                $display("FAIL jump_priority step %0d: next=%h flush=%b, required next=%h flush=%b",
                         i, next, if_id_flush, e.nxt, e.flush);
            end
            tick();
        end
    endtask

    task automatic test_stall_pending();
        step_t st[4];
        exp_t  e;
        st[0] = mk(32'h100, 1, 0, 32'h0,   1, 32'h180, 0, 32'h100, 0);
        st[1] = mk(32'h100, 1, 0, 32'h0,   0, 32'h0,   0, 32'h100, 0);
        st[2] = mk(32'h100, 0, 1, 32'h400, 0, 32'h0,   0, 32'h180, 1);
        st[3] = mk(32'h180, 0, 0, 32'h0,   0, 32'h0,   0, 32'h184, 0);
        for (int i = 0; i < 4; i++) begin
            apply(st[i]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush) begin
                n_err++;
                $display("FAIL stall_pending step %0d: next=%h flush=%b, required next=%h flush=%b",
                         i, next, if_id_flush, e.nxt, e.flush);
            end
            tick();
            if (i == 1) begin
                n_cmp++;
                if (stall_count !== 4'd2) begin
                    n_err++;
                    $display("FAIL stall_count: got %0d, required 2", stall_count);
                end
            end
        end
        n_cmp++;
        if (fetch_count !== 4'd6 || stall_count !== 4'd2) begin
            n_err++;
            $display("FAIL counters_after_stall: fc=%0d sc=%0d, required fc=6 sc=2",
                     fetch_count, stall_count);
        end
    endtask

    task automatic test_wrap_align();
        step_t st[3];
        exp_t  e;
        st[0] = mk(32'hFFFF_FFFC, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0000, 0);
        st[1] = mk(32'h0000_0000, 0, 1, 32'h0000_0123, 0, 32'h0,         0, 32'h0000_0120, 1);
        st[2] = mk(32'h0000_0120, 0, 0, 32'h0,         1, 32'h0000_0337, 0, 32'h0000_0334, 1);
        for (int i = 0; i < 3; i++) begin
            apply(st[i]);
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush) begin
                n_err++;
                $display("FAIL wrap_align step %0d: next=%h flush=%b, required next=%h flush=%b",
                         i, next, if_id_flush, e.nxt, e.flush);
            end
            tick();
        end
    endtask

    task automatic test_halt();
        step_t st[6];
        exp_t  e;
        logic  exp_h;
        st[0] = mk(32'h50, 0, 0, 32'h0,   0, 32'h0,   1, 32'h50, 1);
        st[1] = mk(32'h50, 0, 1, 32'h200, 0, 32'h0,   0, 32'h50, 1);
        st[2] = mk(32'h50, 1, 0, 32'h0,   0, 32'h0,   0, 32'h50, 1);
        st[3] = mk(32'h50, 0, 0, 32'h0,   1, 32'h300, 0, 32'h50, 1);
        st[4] = mk(32'h50, 1, 1, 32'h600, 1, 32'h700, 0, 32'h50, 1);
        st[5] = mk(32'h50, 0, 0, 32'h0,   0, 32'h0,   0, 32'h50, 1);
        for (int i = 0; i < 6; i++) begin
            apply(st[i]);
            #1;
            e = sb.pop_front();
            exp_h = (i > 0);
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush || halted !== exp_h) begin
                n_err++;
                $display("FAIL halt step %0d: next=%h flush=%b halted=%b, required next=%h flush=%b halted=%b",
                         i, next, if_id_flush, halted, e.nxt, e.flush, exp_h);
            end
            tick();
        end
        n_cmp++;
        if (fetch_count !== 4'd9 || stall_count !== 4'd2 || halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_frozen: fc=%0d sc=%0d halted=%b, required fc=9 sc=2 halted=1",
                     fetch_count, stall_count, halted);
        end
        // Reset pulse recovers from HALT.
        reset = 1'b1;
        apply(mk(32'h50, 0, 0, 0, 0, 0, 0, RV, 1));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (next !== e.nxt || if_id_flush !== e.flush || halted !== 1'b0 ||
            fetch_count !== 4'd0 || stall_count !== 4'd0) begin
            n_err++;
            $display("FAIL halt_reset: next=%h flush=%b halted=%b fc=%0d sc=%0d, required next=%h flush=1 halted=0 fc=0 sc=0",
                     next, if_id_flush, halted, fetch_count, stall_count, e.nxt);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_drops_pending();
        exp_t  e;
        // Buffer a redirect under stall, then reset before it is consumed.
        apply(mk(RV, 0, 0, 0, 0, 0, 0, RV, 1));
        tick();
        void'(sb.pop_front());
        apply(mk(32'h800, 1, 1, 32'h900, 0, 32'h0, 0, 32'h800, 0));
        tick();
        void'(sb.pop_front());
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply(mk(32'h800, 0, 0, 0, 0, 0, 0, RV, 1));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (next !== e.nxt || if_id_flush !== e.flush) begin
            n_err++;
            $display("FAIL reset_drop boot: next=%h flush=%b, required next=%h flush=%b",
                     next, if_id_flush, e.nxt, e.flush);
        end
        tick();
        apply(mk(RV, 0, 0, 0, 0, 0, 0, 32'h0040_0004, 0));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (next !== e.nxt || if_id_flush !== e.flush) begin
            n_err++;
            $display("FAIL reset_drop first_run: next=%h flush=%b, required next=%h flush=%b",
                     next, if_id_flush, e.nxt, e.flush);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t        e;
        logic [31:0] p;
        int          exp_fc;
        apply(mk(32'h0, 0, 0, 0, 0, 0, 0, RV, 1));
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (next !== e.nxt || if_id_flush !== e.flush || fetch_count !== 4'd0) begin
            n_err++;
            $display("FAIL sat_boot: next=%h flush=%b fc=%0d, required next=%h flush=%b fc=0",
                     next, if_id_flush, fetch_count, e.nxt, e.flush);
        end
        tick();
        p = RV;
        for (int i = 0; i < 17; i++) begin
            apply(mk(p, 0, 0, 0, 0, 0, 0, p + 32'd4, 0));
            #1;
            e = sb.pop_front();
            n_cmp++;
            if (next !== e.nxt || if_id_flush !== e.flush) begin
                n_err++;
                $display("FAIL sat_seq step %0d: next=%h flush=%b, required next=%h flush=%b",
                         i, next, if_id_flush, e.nxt, e.flush);
            end
            tick();
            p = p + 32'd4;
            exp_fc = (i + 1 > 15) ? 15 : i + 1;
            if (i >= 13) begin
                n_cmp++;
                if (fetch_count !== exp_fc[CNT_W-1:0]) begin
                    n_err++;
                    $display("FAIL fetch_saturate after %0d cycles: got %0d, required %0d",
                             i + 1, fetch_count, exp_fc);
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        pc            = 32'h0;
        stall         = 1'b0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        halt_req      = 1'b0;
        test_reset();
        test_jump_priority();
        test_stall_pending();
        test_wrap_align();
        test_halt();
        test_saturation();
        test_reset_drops_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
